// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - Gowin rPLL reset sequencer, lock qualifier and system reset generator
module pll_lock_supervisor #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock_in,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic       fault,
    output logic [7:0] relock_count
);

    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         relock_q, relock_d;
    logic               lock_meta_q, lock_s_q;
    logic               pll_reset_q, sys_reset_q, locked_q, fault_q;
    logic               pll_reset_d, sys_reset_d, locked_d, fault_d;

    // Two-flop synchronizer: lock_in is asynchronous to clk, only lock_s_q is used downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock_in;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic; the single shared counter restarts on every state change
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_PLL_RST;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            S_STABLE: begin
                // A dropout here only restarts the lock wait; no retry is spent
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = S_PLL_RST;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the same edge as the state
    always_comb begin
        pll_reset_d = (state_d == S_PLL_RST);
        sys_reset_d = (state_d != S_RUN);
        locked_d    = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            relock_q    <= 8'd0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign sys_reset    = sys_reset_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - event scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lock_in = 1'b0;
    logic       pll_reset, sys_reset, locked, fault;
    logic [7:0] relock_count;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(50),
        .PLL_RESET_CYCLES   (4),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock_in     (lock_in),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .fault       (fault),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [11:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [11:0] prev;

    // {pll_reset, sys_reset, locked, fault, relock_count}
    function automatic logic [11:0] mk(logic pr, logic sr, logic lk, logic ft, int rc);
        logic [7:0] r;
        r = 8'(rc);
        return {pr, sr, lk, ft, r};
    endfunction

    function automatic logic [11:0] outs();
        return {pll_reset, sys_reset, locked, fault, relock_count};
    endfunction

    localparam logic [11:0] RST_V = 12'hC00;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every change of the output vector must match the next expected event
    always @(negedge clk) begin
        logic [11:0] cur;
        ev_t e;
        if (mon_en) begin
            cur = outs();
            if (cur !== prev) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event: cyc=%0d got=%h, required no change from %h", cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        errors = errors + 1;
                        $display("FAIL event: got cyc=%0d val=%h, required cyc=%0d val=%h", cyc, cur, e.cyc, e.val);
                    end
                end
                prev = cur;
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                e = exp_q.pop_front();
                $display("FAIL missed_event: at cyc=%0d val=%h still, required cyc=%0d val=%h", cyc, cur, e.cyc, e.val);
            end
        end
    end

    task automatic push(int at, logic [11:0] v);
        ev_t e;
        e.cyc = at;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(string name, logic [11:0] v);
        checks = checks + 1;
        if (outs() !== v) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, outs(), v);
        end
    endtask

    // Assert reset between edges and confirm outputs reset without a clock edge
    task automatic apply_reset(logic new_lock);
        #1;
        push(cyc, RST_V);
        reset = 1'b1;
        #1;
        check_now("async_reset", RST_V);
        lock_in = new_lock;
        tick(3);
    endtask

    initial begin
        int r;
        int d;
        prev = RST_V;
        tick(3);
        check_now("reset_state", RST_V);
        mon_en = 1'b1;

        // Nominal lock
        reset = 1'b0;
        r = cyc;
        push(r + 4, mk(0, 1, 0, 0, 0));
        tick(10);
        lock_in = 1'b1;
        push(r + 21, mk(0, 0, 1, 0, 0));
        tick(15);

        // Single-cycle lock loss in RUN, repeated past saturation
        for (int k = 1; k <= 300; k++) begin
            int rc;
            rc = (k > 255) ? 255 : k;
            d = cyc;
            lock_in = 1'b0;
            push(d + 3,  mk(1, 1, 0, 0, rc));
            push(d + 7,  mk(0, 1, 0, 0, rc));
            push(d + 16, mk(0, 0, 1, 0, rc));
            tick(1);
            lock_in = 1'b1;
            tick(19);
        end
        check_now("relock_saturated", mk(0, 0, 1, 0, 255));

        // Async reset mid-RUN, then restart with lock already present
        apply_reset(1'b1);
        check_now("reset_held", RST_V);
        reset = 1'b0;
        r = cyc;
        push(r + 4,  mk(0, 1, 0, 0, 0));
        push(r + 13, mk(0, 0, 1, 0, 0));
        tick(20);

        // Unstable qualification
        apply_reset(1'b0);
        reset = 1'b0;
        r = cyc;
        push(r + 4, mk(0, 1, 0, 0, 0));
        tick(10);
        lock_in = 1'b1;
        tick(5);
        lock_in = 1'b0;
        tick(1);
        lock_in = 1'b1;
        push(r + 27, mk(0, 0, 1, 0, 0));
        tick(15);

        // Timeout, retry, fault
        apply_reset(1'b0);
        reset = 1'b0;
        r = cyc;
        push(r + 4,   mk(0, 1, 0, 0, 0));
        push(r + 54,  mk(1, 1, 0, 0, 0));
        push(r + 58,  mk(0, 1, 0, 0, 0));
        push(r + 108, mk(1, 1, 0, 0, 0));
        push(r + 112, mk(0, 1, 0, 0, 0));
        push(r + 162, mk(0, 1, 0, 1, 0));
        tick(262);
        check_now("fault_hold", mk(0, 1, 0, 1, 0));

        // Async reset mid-FAULT, then recovery after one retry
        apply_reset(1'b0);
        reset = 1'b0;
        r = cyc;
        push(r + 4,  mk(0, 1, 0, 0, 0));
        push(r + 54, mk(1, 1, 0, 0, 0));
        push(r + 58, mk(0, 1, 0, 0, 0));
        tick(60);
        lock_in = 1'b1;
        push(r + 71, mk(0, 0, 1, 0, 0));
        tick(15);
        check_now("recovered_run", mk(0, 0, 1, 0, 0));

        // Permanent loss: full retry budget available again
        d = cyc;
        lock_in = 1'b0;
        push(d + 3,   mk(1, 1, 0, 0, 1));
        push(d + 7,   mk(0, 1, 0, 0, 1));
        push(d + 57,  mk(1, 1, 0, 0, 1));
        push(d + 61,  mk(0, 1, 0, 0, 1));
        push(d + 111, mk(1, 1, 0, 0, 1));
        push(d + 115, mk(0, 1, 0, 0, 1));
        push(d + 165, mk(0, 1, 0, 1, 1));
        tick(200);
        check_now("final_fault", mk(0, 1, 0, 1, 1));

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises a Gowin rPLL from its free-running input clock. It pulses the PLL reset, waits for a stable LOCK, and holds the system reset until lock has been continuously stable. On any later loss of lock it re-asserts the system reset and restarts the PLL. It sits between the board clock pin / PLL wrapper and all logic clocked by the PLL output, and it drives the PLL RESET pin that the bare wrapper otherwise ties low.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release.
- LOCK_TIMEOUT_CYCLES, 27000: cycles to wait for lock after PLL reset (1 ms at 27 MHz).
- PLL_RESET_CYCLES, 16: width of each pll_reset pulse.
- MAX_RETRIES, 3: lock timeouts tolerated before declaring fault.
- CNT_W, 16: width of the shared internal counter; must hold all three cycle parameters.

- clk  in  1  free-running board clock (27 MHz), never the PLL output.
- reset  in  1  asynchronous, active-high; clears all state.
- lock_in  in  1  PLL LOCK, asynchronous to clk.
- pll_reset  out  1  drives PLL RESET, active-high.
- sys_reset  out  1  active-high reset for PLL-clocked logic.
- locked  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- relock_count  out  8  number of RUN→lock-loss events, saturating at 255.

## Operation
- lock_in passes through a 2-FF synchronizer, giving lock_s. Only lock_s is used.
- All outputs are registered and decoded from state.
- States:
  - PLL_RST: pll_reset=1, sys_reset=1. After PLL_RESET_CYCLES cycles → WAIT_LOCK, counter cleared.
  - WAIT_LOCK: pll_reset=0, sys_reset=1.
    - lock_s=1 → STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0 → timeout.
    - On timeout with retry_cnt==MAX_RETRIES → FAULT. Otherwise retry_cnt+1 → PLL_RST.
  - STABLE: sys_reset=1.
    - lock_s=0 → WAIT_LOCK, counter cleared. The timeout restarts and no retry is consumed.
    - Counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1 → RUN, retry_cnt cleared.
  - RUN: sys_reset=0, locked=1.
    - lock_s=0 → PLL_RST, relock_count+1 (saturating).
  - FAULT: pll_reset=0, sys_reset=1, fault=1. Terminal; only reset exits it.
- Reset values: state=PLL_RST, pll_reset=1, sys_reset=1, locked=0, fault=0, relock_count=0, retry_cnt=0, counter=0.
- Asserting reset in any state, including mid-RUN, immediately forces these values. relock_count is also cleared.
- Exactly one counter is used; it is cleared on every state transition.
- A lock_s glitch of a single cycle in STABLE restarts qualification, and in RUN triggers a full PLL restart. No filtering beyond the synchronizer.

## Timing
- Reset deassertion → first PLL_RST cycle; pll_reset stays high for exactly PLL_RESET_CYCLES cycles.
- lock_in rising (and held) at clk edge E:
  - lock_s is high from E+2.
  - STABLE is entered at E+3.
  - sys_reset falls and locked rises at E+3+LOCK_STABLE_CYCLES.
- lock_in falling in RUN at edge E:
  - sys_reset=1, locked=0 and pll_reset=1 at E+3.
  - relock_count increments in the same cycle.
- Timeout fires LOCK_TIMEOUT_CYCLES cycles after WAIT_LOCK entry. The next state (PLL_RST or FAULT) is visible on the following edge.
- Total PLL reset attempts before FAULT: MAX_RETRIES+1.
- Outputs are glitch-free: every output is a flop, with no combinational path from lock_in.

## Test plan
All scenarios use LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50, PLL_RESET_CYCLES=4, MAX_RETRIES=2.

- **Nominal lock:** release reset, raise lock_in 10 cycles later and hold → pll_reset high for exactly 4 cycles; sys_reset falls 11 cycles after the lock_in sample edge; locked=1, fault=0, relock_count=0.
- **Unstable qualification:** lock_in high for 5 cycles, low for 1, then high and held → no release at the first window; sys_reset falls 11 cycles after the second rise; retry_cnt unaffected.
- **Timeout/retry/fault:** lock_in held low → three pll_reset pulses of 4 cycles, each separated by 50 WAIT_LOCK cycles; fault=1 after the third timeout; pll_reset=0 and sys_reset=1 from then on.
- **Recovery after retry:** lock_in low through one timeout, then raised during the second WAIT_LOCK → reaches RUN, fault=0; a subsequent timeout sequence again allows 3 attempts, proving retry_cnt was cleared.
- **Loss of lock in RUN:** drop lock_in for 1 cycle while in RUN → sys_reset=1 three cycles later; relock_count=1; new 4-cycle pll_reset pulse. Repeat 300 times → relock_count saturates at 255.
- **Async reset mid-RUN and mid-FAULT:** assert reset between clock edges → all outputs reach their reset values without waiting for a clk edge; relock_count=0; the sequence restarts at PLL_RST.
